// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions: reset PC, the NOP word, fetch state encoding and
// the exception code for an address error on fetch.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [4:0]  ADEL     = 5'h04;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction ROM read port: chip enable and byte address out, with a
// combinational read word returned in the same cycle.
interface inst_fetch_if;

  logic        inst_ce;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;

  modport master (output inst_ce, output inst_addr, input inst_data);
  modport slave  (input inst_ce, input inst_addr, output inst_data);

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// Generic pipeline register holding PC, instruction, valid and address-error
// flags; bubble takes priority over load, otherwise the contents hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic        i_valid,
  input  logic        i_adel,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid,
  output logic        o_adel
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_adel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= 32'h0;
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
    end else if (i_bubble) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= i_valid;
      r_adel  <= i_adel;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;
  assign o_adel  = r_adel;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC and fetch FSM driving the ROM port, feeding the
// IF/ID register with stall, delayed-branch, flush and misaligned-fetch handling.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_stall,
  input  logic         i_flush,
  input  logic [31:0]  i_flush_pc,
  input  logic         i_branch_taken,
  input  logic [31:0]  i_branch_target,
  inst_fetch_if.master rom,
  output logic [31:0]  o_id_pc,
  output logic [31:0]  o_id_inst,
  output logic         o_id_valid,
  output logic         o_id_adel
);

  import cpu_defs::*;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         w_aligned;
  logic         w_ifLoad;
  logic         w_ifBubble;
  logic [31:0]  w_ifInst;
  logic         w_ifAdel;

  assign w_aligned     = (r_pc[1:0] == 2'b00);
  assign rom.inst_ce   = (r_state == RUN) && w_aligned;
  assign rom.inst_addr = r_pc;

  // A misaligned PC never reaches the ROM; its IF/ID entry is a NOP tagged with ADEL.
  always_comb begin
    w_ifLoad   = 1'b0;
    w_ifBubble = 1'b0;
    w_ifInst   = rom.inst_data;
    w_ifAdel   = 1'b0;
    case (r_state)
      RUN: begin
        if (i_flush) begin
          w_ifBubble = 1'b1;
        end else if (!i_stall) begin
          w_ifLoad = 1'b1;
          if (!w_aligned) begin
            w_ifInst = NOP_INST;
            w_ifAdel = 1'b1;
          end
        end
      end
      ERR: begin
        w_ifBubble = i_flush || !i_stall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          if (i_flush) begin
            r_pc <= i_flush_pc;
          end else if (!i_stall) begin
            if (!w_aligned)          r_state <= ERR;
            else if (i_branch_taken) r_pc    <= i_branch_target;
            else                     r_pc    <= r_pc + 32'd4;
          end
        end
        ERR: begin
          if (i_flush) begin
            r_pc    <= i_flush_pc;
            r_state <= RUN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_ifLoad),
    .i_bubble (w_ifBubble),
    .i_pc     (r_pc),
    .i_inst   (w_ifInst),
    .i_valid  (1'b1),
    .i_adel   (w_ifAdel),
    .o_pc     (o_id_pc),
    .o_inst   (o_id_inst),
    .o_valid  (o_id_valid),
    .o_adel   (o_id_adel)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a behavioural ROM answers reads and each step
// compares the fetch outputs against hand-computed values.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flushPc;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        idValid;
  logic        idAdel;
  int          compared;
  int          mismatched;

  inst_fetch_if romIf ();

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_flush_pc      (flushPc),
    .i_branch_taken  (branchTaken),
    .i_branch_target (branchTarget),
    .rom             (romIf.master),
    .o_id_pc         (idPc),
    .o_id_inst       (idInst),
    .o_id_valid      (idValid),
    .o_id_adel       (idAdel)
  );

  // ROM contents: the two boot words, then an address-derived pattern.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    case (a)
      32'h0:   romWord = 32'h0000_f025;
      32'h4:   romWord = 32'h241d_1000;
      default: romWord = {~a[15:0], a[15:0]};
    endcase
  endfunction

  always_comb romIf.inst_data = romWord(romIf.inst_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic fl, input logic [31:0] flPc,
                               input logic br, input logic [31:0] brTgt);
    stall        = st;
    flush        = fl;
    flushPc      = flPc;
    branchTaken  = br;
    branchTarget = brTgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    stall        = 1'b0;
    flush        = 1'b0;
    flushPc      = 32'h0;
    branchTaken  = 1'b0;
    branchTarget = 32'h0;

    #3;
    checkOutput("rst_ce", romIf.inst_ce, 0);
    checkOutput("rst_addr", romIf.inst_addr, 32'h0);
    checkOutput("rst_idpc", idPc, 32'h0);
    checkOutput("rst_idinst", idInst, 32'h0);
    checkOutput("rst_valid", idValid, 0);
    checkOutput("rst_adel", idAdel, 0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("idle_ce", romIf.inst_ce, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("run_ce", romIf.inst_ce, 1);
    checkOutput("run_addr", romIf.inst_addr, 32'h0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("boot0_inst", idInst, 32'h0000_f025);
    checkOutput("boot0_pc", idPc, 32'h0);
    checkOutput("boot0_valid", idValid, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("boot1_inst", idInst, 32'h241d_1000);
    checkOutput("boot1_pc", idPc, 32'h4);

    repeat (6) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pre_stall_addr", romIf.inst_addr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("stall_addr", romIf.inst_addr, 32'h20);
      checkOutput("stall_idpc", idPc, 32'h1c);
      checkOutput("stall_idinst", idInst, 32'hffe3_001c);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("resume_idpc", idPc, 32'h20);
    checkOutput("resume_idinst", idInst, 32'hffdf_0020);
    checkOutput("resume_addr", romIf.inst_addr, 32'h24);

    repeat (8) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pre_br_addr", romIf.inst_addr, 32'h44);
    applyStimulus(0, 0, 0, 1, 32'h180);
    checkOutput("slot_idpc", idPc, 32'h44);
    checkOutput("slot_idinst", idInst, 32'hffbb_0044);
    checkOutput("br_addr", romIf.inst_addr, 32'h180);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("br_tgt_idpc", idPc, 32'h180);
    checkOutput("br_tgt_valid", idValid, 1);

    applyStimulus(1, 1, 32'h380, 1, 32'h500);
    checkOutput("flush_addr", romIf.inst_addr, 32'h380);
    checkOutput("flush_valid", idValid, 0);
    checkOutput("flush_inst", idInst, 32'h0);
    checkOutput("flush_ce", romIf.inst_ce, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post_flush_idpc", idPc, 32'h380);
    checkOutput("post_flush_valid", idValid, 1);

    applyStimulus(0, 0, 0, 1, 32'h102);
    checkOutput("mis_slot_idpc", idPc, 32'h384);
    checkOutput("mis_addr", romIf.inst_addr, 32'h102);
    checkOutput("mis_ce", romIf.inst_ce, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("adel_idpc", idPc, 32'h102);
    checkOutput("adel_flag", idAdel, 1);
    checkOutput("adel_valid", idValid, 1);
    checkOutput("adel_inst", idInst, 32'h0);
    checkOutput("err_ce", romIf.inst_ce, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("err_bubble_valid", idValid, 0);
    checkOutput("err_bubble_adel", idAdel, 0);
    checkOutput("err_pc_frozen", romIf.inst_addr, 32'h102);
    applyStimulus(0, 1, 32'h380, 0, 0);
    checkOutput("err_flush_addr", romIf.inst_addr, 32'h380);
    checkOutput("err_flush_ce", romIf.inst_ce, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart_idpc", idPc, 32'h380);
    checkOutput("restart_valid", idValid, 1);

    applyStimulus(0, 1, 32'hffff_fffc, 0, 0);
    checkOutput("pre_wrap_addr", romIf.inst_addr, 32'hffff_fffc);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_idpc", idPc, 32'hffff_fffc);
    checkOutput("wrap_addr", romIf.inst_addr, 32'h0);

    applyStimulus(1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ce", romIf.inst_ce, 0);
    checkOutput("async_rst_addr", romIf.inst_addr, 32'h0);
    checkOutput("async_rst_valid", idValid, 0);
    checkOutput("async_rst_idpc", idPc, 32'h0);
    stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rerelease_idle_ce", romIf.inst_ce, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rerelease_run_ce", romIf.inst_ce, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
